// File: rtl/brcmp_pkg.sv
// ============================================================================
// brcmp_pkg : funct3 condition codes and skid-buffer state encoding
// Revision  : 1.0
// ============================================================================
`default_nettype none

package brcmp_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_t;

endpackage

`default_nettype wire

// File: rtl/compare_core.sv
// ============================================================================
// compare_core : combinational RV32I branch / set-less-than condition evaluator
// Revision     : 1.0
// ============================================================================
`default_nettype none

module compare_core
    import brcmp_pkg::*;
#(
    parameter int NUM_SIZE = 32
) (
    input  logic [NUM_SIZE-1:0] dIn0,
    input  logic [NUM_SIZE-1:0] dIn1,
    input  logic [NUM_SIZE-1:0] diff,
    input  logic                overflow,
    input  logic [2:0]          funct3,
    output logic                cond
);

    logic eq;
    logic lt;
    logic ltu;

    // Signed less-than reuses the subtractor: sign of the difference, corrected by overflow.
    assign eq  = (diff == '0);
    assign lt  = diff[NUM_SIZE-1] ^ overflow;
    assign ltu = (dIn0 < dIn1);

    always_comb begin
        cond = 1'b0;
        case (funct3)
            F3_BEQ:  cond = eq;
            F3_BNE:  cond = !eq;
            F3_SLT:  cond = lt;
            F3_SLTU: cond = ltu;
            F3_BLT:  cond = lt;
            F3_BGE:  cond = !lt;
            F3_BLTU: cond = ltu;
            F3_BGEU: cond = !ltu;
            default: cond = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/branch_compare_stage.sv
// ============================================================================
// branch_compare_stage : registered branch/SLT condition with valid/ready;
//                        BRCMP_SKID_EN selects a two-entry skid buffer.
// Revision             : 1.0
// ============================================================================
`default_nettype none

module branch_compare_stage
    import brcmp_pkg::*;
#(
    parameter int NUM_SIZE = 32,
    parameter int TAG_SIZE = 5
) (
    input  logic                clk,
    input  logic                rstN,
    input  logic                inValid,
    output logic                inReady,
    input  logic [NUM_SIZE-1:0] dIn0,
    input  logic [NUM_SIZE-1:0] dIn1,
    input  logic [NUM_SIZE-1:0] diff,
    input  logic                overflow,
    input  logic [2:0]          funct3,
    input  logic [TAG_SIZE-1:0] tagIn,
    output logic                outValid,
    input  logic                outReady,
    output logic                cond,
    output logic [NUM_SIZE-1:0] result,
    output logic [TAG_SIZE-1:0] tagOut
);

    logic cond_next;
    logic accept;
    logic xfer;

    compare_core #(
        .NUM_SIZE (NUM_SIZE)
    ) u_compare_core (
        .dIn0     (dIn0),
        .dIn1     (dIn1),
        .diff     (diff),
        .overflow (overflow),
        .funct3   (funct3),
        .cond     (cond_next)
    );

    assign accept = inValid && inReady;
    assign xfer   = outValid && outReady;
    assign result = {{(NUM_SIZE-1){1'b0}}, cond};

`ifdef BRCMP_SKID_EN
    skid_state_t         state;
    logic                full;
    logic                skid_cond;
    logic [TAG_SIZE-1:0] skid_tag;

    // full is a register, so inReady never depends on outReady.
    assign inReady = rstN && !full;

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state     <= SKID_EMPTY;
            full      <= 1'b0;
            outValid  <= 1'b0;
            cond      <= 1'b0;
            tagOut    <= '0;
            skid_cond <= 1'b0;
            skid_tag  <= '0;
        end else begin
            case (state)
                SKID_EMPTY: begin
                    if (accept) begin
                        outValid <= 1'b1;
                        cond     <= cond_next;
                        tagOut   <= tagIn;
                        state    <= SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    if (accept && xfer) begin
                        cond   <= cond_next;
                        tagOut <= tagIn;
                    end else if (accept) begin
                        skid_cond <= cond_next;
                        skid_tag  <= tagIn;
                        full      <= 1'b1;
                        state     <= SKID_TWO;
                    end else if (xfer) begin
                        outValid <= 1'b0;
                        state    <= SKID_EMPTY;
                    end
                end
                SKID_TWO: begin
                    if (xfer) begin
                        cond   <= skid_cond;
                        tagOut <= skid_tag;
                        full   <= 1'b0;
                        state  <= SKID_ONE;
                    end
                end
                default: begin
                    state    <= SKID_EMPTY;
                    full     <= 1'b0;
                    outValid <= 1'b0;
                end
            endcase
        end
    end
`else
    assign inReady = rstN && (!outValid || outReady);

    always_ff @(posedge clk) begin
        if (!rstN) begin
            outValid <= 1'b0;
            cond     <= 1'b0;
            tagOut   <= '0;
        end else if (accept) begin
            outValid <= 1'b1;
            cond     <= cond_next;
            tagOut   <= tagIn;
        end else if (xfer) begin
            outValid <= 1'b0;
        end
    end
`endif

endmodule

`default_nettype wire

// File: doc/branch_compare_stage.md
# branch_compare_stage

Execute-stage consumer of the subtractor output. Takes the operand pair, the subtractor's difference, and its signed-overflow flag. Evaluates the RV32I branch/set-less-than condition selected by `funct3` and registers the result behind a valid/ready handshake. The result goes to the branch resolution and writeback logic. An optional skid buffer provides full throughput with a registered `inReady`.

## Interface
- `NUM_SIZE`, 32, operand/difference width
- `TAG_SIZE`, 5, opaque sideband tag (e.g. rd index) carried with each operation

- `clk` input 1, sole clock, rising edge
- `rstN` input 1, synchronous active-low reset; one clock, synchronous, active-low is fixed
- `inValid` input 1, upstream operation present
- `inReady` output 1, stage can accept this cycle
- `dIn0` input NUM_SIZE, minuend (rs1)
- `dIn1` input NUM_SIZE, subtrahend (rs2)
- `diff` input NUM_SIZE, dIn0 − dIn1 from the subtractor
- `overflow` input 1, two's-complement signed overflow of that subtraction
- `funct3` input 3, condition select
- `tagIn` input TAG_SIZE, sideband tag
- `outValid` output 1, registered result valid
- `outReady` input 1, downstream accepts
- `cond` output 1, condition outcome
- `result` output NUM_SIZE, {zeros, cond} (SLT/SLTU writeback value)
- `tagOut` output TAG_SIZE, tag of the presented result

## Operation
- Flags, computed combinationally from inputs:
  - eq = (diff == 0)
  - lt = diff[NUM_SIZE−1] ^ overflow
  - ltu = unsigned dIn0 < dIn1, computed locally
- funct3 selects cond:
  - 000 eq (BEQ)
  - 001 !eq (BNE)
  - 010 lt (SLT)
  - 011 ltu (SLTU)
  - 100 lt (BLT)
  - 101 !lt (BGE)
  - 110 ltu (BLTU)
  - 111 !ltu (BGEU)
- No reserved codes.
- An operation is accepted when `inValid && inReady`. cond, result and tag are captured together.
- A result transfers when `outValid && outReady`.
- Output fields hold stable while `outValid && !outReady`.
- Ordering is strictly FIFO. No operation is dropped or duplicated.

## Timing
- Reset (rstN low at a rising edge):
  - outValid=0, cond=0, result=0, tagOut=0
  - all internal valid bits cleared
  - inReady=0 while rstN is low
  - inReady=1 in the first cycle after release
- Reset mid-operation discards all held entries with no drain.
- Latency: an operation accepted in cycle N is presented with outValid=1 in cycle N+1.
- Throughput: one operation per cycle while outReady=1.
- An accept and a transfer in the same cycle are legal in all states. The new entry replaces the departing one.

## Configuration
- `BRCMP_SKID_EN` defined:
  - Two-entry skid buffer with states EMPTY, ONE, TWO.
  - EMPTY→ONE on accept.
  - ONE→ONE on accept+transfer.
  - ONE→TWO on accept without transfer; the entry goes to the skid register.
  - ONE→EMPTY on transfer only.
  - TWO→ONE on transfer; the skid entry moves to the output register.
  - inReady = (state != TWO), driven from a register with no combinational path from outReady.
  - Accept is impossible in TWO.
- `BRCMP_SKID_EN` undefined:
  - Single output register.
  - inReady = !outValid || outReady (combinational from outReady).
  - Same latency and ordering.

## Structure
- Package `brcmp_pkg` holds:
  - funct3 localparams (F3_BEQ … F3_BGEU)
  - skid state encoding (EMPTY/ONE/TWO)
- One sub-module, `compare_core`: purely combinational; computes eq/lt/ltu and cond from dIn0, dIn1, diff, overflow and funct3.
- The top handles the handshake and storage.

## Test plan
- dIn0=5, dIn1=5, diff=0, ovf=0, funct3=000, tag=3 → next cycle outValid=1, cond=1, result=1, tagOut=3.
- dIn0=0x80000000, dIn1=1, diff=0x7FFFFFFF, ovf=1, funct3=100 → cond=1 (signed −2^31 < 1). Same operands with funct3=110 → cond=0.
- All 8 funct3 codes on dIn0=0xFFFFFFFF, dIn1=1 (diff=0xFFFFFFFE, ovf=0) → cond sequence 0,1,1,0,1,0,0,1.
- outReady=0 while 3 ops are offered back-to-back. With skid: 2 accepted, inReady falls in the cycle after the second accept. Without skid: 1 accepted. Raise outReady → results drain in order, no loss.
- Continuous inValid=1, outReady=1 for 10 ops → 10 results on consecutive cycles, tags 0..9 in order.
- Assert rstN=0 with 2 entries held → the following cycle outValid=0, inReady=0. After release: inReady=1, and no stale results appear.
